// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, bus layouts,
// stall-vector bit positions and load-type codes.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 79;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_WD = 38;
  localparam int STALL_WD     = 6;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  typedef struct packed {
    logic [2:0]  mem_op;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_to_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half of a loaded word and sign/zero-extends it.
// Purely combinational; no flow control.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    // Halfword select uses addr[1] only; an odd address is not trapped here.
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (mem_op)
      LD_B:    data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   data = {24'd0, byte_v};
      LD_H:    data = {{16{half_v[15]}}, half_v};
      LD_HU:   data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, holds the SRAM read word across stalls, selects writeback data.
// Latency 1 cycle; stall[3] holds the stage, stall[3] without stall[4] inserts a bubble.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
  output logic                    mem_is_load
);

  ex_to_mem_t  bus_r;
  logic        first_r;
  logic        buf_valid_r;
  logic [31:0] rdata_buf;

  logic        bubble;
  logic        advance;
  logic [31:0] rdata_eff;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  mem_to_wb_t  wb;

  assign bubble  = (stall[STALL_MEM] == STOP) && (stall[STALL_WB] == NO_STOP);
  assign advance = (stall[STALL_MEM] == NO_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r <= '0;
    end else if (bubble) begin
      bus_r <= '0;
    end else if (advance) begin
      bus_r <= ex_to_mem_bus;
    end
  end

  // The SRAM word is only guaranteed on the first MEM cycle; EX may re-drive
  // the SRAM while MEM is stalled, so the word is latched on that first cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r     <= 1'b0;
      buf_valid_r <= 1'b0;
      rdata_buf   <= '0;
    end else if (bubble) begin
      first_r     <= 1'b0;
      buf_valid_r <= 1'b0;
    end else if (advance) begin
      first_r     <= 1'b1;
      buf_valid_r <= 1'b0;
    end else begin
      first_r <= 1'b0;
      if (first_r) begin
        buf_valid_r <= 1'b1;
        rdata_buf   <= data_sram_rdata;
      end
    end
  end

  assign rdata_eff = buf_valid_r ? rdata_buf : data_sram_rdata;

  load_align u_load_align (
    .mem_op (bus_r.mem_op),
    .addr   (bus_r.ex_result[1:0]),
    .rdata  (rdata_eff),
    .data   (load_data)
  );

  assign rf_wdata    = bus_r.sel_rf_res ? load_data : bus_r.ex_result;
  assign mem_is_load = bus_r.sel_rf_res && bus_r.data_ram_en && (bus_r.data_ram_wen == 4'd0);

  always_comb begin
    wb          = '0;
    wb.pc       = bus_r.pc;
    wb.rf_we    = bus_r.rf_we;
    wb.rf_waddr = bus_r.rf_waddr;
    wb.rf_wdata = rf_wdata;
  end

  assign mem_to_wb_bus = wb;
  assign mem_to_id_bus = {bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

endmodule
